// File: rtl/mux_scan_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mux_scan_ctrl_pkg : shared constants and FSM encoding for the mux scanner
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mux_scan_ctrl_pkg;

  localparam int N_ENTRIES_DEF = 25;
  localparam int DATA_W_DEF    = 8;
  localparam int SEL_W_DEF     = 5;

  localparam int ST_W = 2;
  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_SCAN = 2'd1;
  localparam logic [ST_W-1:0] ST_DONE = 2'd2;

endpackage

`default_nettype wire

// File: rtl/mux_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// mux_scan_ctrl_if : valid/ready sample stream carrying data, index and last
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface mux_scan_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 5
);

  logic [DATA_W-1:0] out_data;
  logic [SEL_W-1:0]  out_idx;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output out_data,
    output out_idx,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_idx,
    input  out_valid,
    input  out_last,
    output out_ready
  );

endinterface

`default_nettype wire

// File: rtl/mux_scan_ctrl.sv
// ---------------------------------------------------------------------------
// mux_scan_ctrl : steps an external N:1 mux, streams samples, checks solved
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mux_scan_ctrl
  import mux_scan_ctrl_pkg::*;
#(
  parameter int N_ENTRIES = N_ENTRIES_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int SEL_W     = SEL_W_DEF
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              start,
  input  wire logic              abort,
  output logic [SEL_W-1:0]       sel,
  input  wire logic [DATA_W-1:0] mux_y,
  mux_scan_ctrl_if.master        stream,
  output logic                   busy,
  output logic                   done,
  output logic                   match_all
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_ENTRIES - 1);
  localparam int CMP_W = (DATA_W > SEL_W) ? DATA_W : SEL_W;

  logic [ST_W-1:0]   state;
  logic [SEL_W-1:0]  cnt;
  logic              loaded_all;
  logic              match_acc;
  logic [DATA_W-1:0] data_q;
  logic [SEL_W-1:0]  idx_q;
  logic              valid_q;
  logic              last_q;

  logic ld;
  logic cell_ok;
  logic accept;

  // Select comes straight from the registered counter so mux_y settles
  // within the same cycle it is sampled.
  assign sel     = (state == ST_SCAN) ? cnt : '0;
  assign ld      = (state == ST_SCAN) && (!valid_q || stream.out_ready) && !loaded_all;
  assign cell_ok = (CMP_W'(mux_y) == CMP_W'(cnt));
  assign accept  = valid_q && stream.out_ready;

  assign busy = (state == ST_SCAN);
  assign done = (state == ST_DONE);

  assign stream.out_data  = data_q;
  assign stream.out_idx   = idx_q;
  assign stream.out_valid = valid_q;
  assign stream.out_last  = last_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      loaded_all <= 1'b0;
      match_acc  <= 1'b0;
      match_all  <= 1'b0;
      data_q     <= '0;
      idx_q      <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
    end else if (abort) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      loaded_all <= 1'b0;
      match_all  <= 1'b0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_SCAN;
            cnt        <= '0;
            loaded_all <= 1'b0;
            match_acc  <= 1'b1;
            match_all  <= 1'b0;
          end
        end
        ST_SCAN: begin
          if (ld) begin
            data_q    <= mux_y;
            idx_q     <= cnt;
            last_q    <= (cnt == LAST_IDX);
            valid_q   <= 1'b1;
            match_acc <= match_acc & cell_ok;
            if (cnt == LAST_IDX) begin
              loaded_all <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else if (accept) begin
            valid_q <= 1'b0;
          end
          if (accept && last_q) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          match_all <= match_acc;
          valid_q   <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mux_scan_ctrl : directed scoreboard bench for the mux scan sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mux_scan_ctrl;

  localparam int N = 25;

  typedef struct packed {
    logic [4:0] idx;
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic [4:0] sel;
  logic [7:0] mux_y;
  logic       busy;
  logic       done;
  logic       match_all;
  logic [7:0] mem [0:N-1];

  mux_scan_ctrl_if #(.DATA_W(8), .SEL_W(5)) strm ();

  mux_scan_ctrl #(.N_ENTRIES(N), .DATA_W(8), .SEL_W(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .sel       (sel),
    .mux_y     (mux_y),
    .stream    (strm.master),
    .busy      (busy),
    .done      (done),
    .match_all (match_all)
  );

  always #5 clk = ~clk;

  // External board mux model
  assign mux_y = (sel < 5'(N)) ? mem[sel] : 8'h00;

  int    errors = 0;
  int    checks = 0;
  int    edge_n = 0;
  int    mode = 0;
  bit    timing_on = 1'b0;
  int    beats_seen = 0;
  int    dones_seen = 0;
  bit    hold_valid = 1'b0;
  beat_t held;
  beat_t sb [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t cur_beat();
    beat_t b;
    b.idx  = strm.out_idx;
    b.data = strm.out_data;
    b.last = strm.out_last;
    return b;
  endfunction

  // Drive ready for the coming edge, score whatever that edge accepts, advance.
  task automatic tick();
    beat_t b;
    beat_t e;
    strm.out_ready = (mode == 0) ? 1'b1 : ((edge_n % 4 == 0) || (edge_n % 4 == 3));
    chk("sel_range", 32'(sel <= 5'(N - 1)), 32'd1);
    b = cur_beat();
    if (hold_valid) begin
      chk("stall_valid", 32'(strm.out_valid), 32'd1);
      chk("stall_beat", 32'(b), 32'(held));
      hold_valid = 1'b0;
    end
    if (strm.out_valid) begin
      if (strm.out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", 32'(b), 32'h0fff_ffff);
        end else begin
          e = sb.pop_front();
          chk("beat", 32'(b), 32'(e));
          if (timing_on) chk("beat_time", 32'(edge_n), 32'(int'(e.idx) + 2));
        end
        beats_seen++;
      end else begin
        hold_valid = 1'b1;
        held = b;
      end
    end
    if (done) begin
      dones_seen++;
      if (timing_on) chk("done_time", 32'(edge_n), 32'd27);
    end
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic start_frame();
    beat_t b;
    for (int i = 0; i < N; i++) begin
      b.idx  = 5'(i);
      b.data = mem[i];
      b.last = (i == N - 1);
      sb.push_back(b);
    end
    beats_seen = 0;
    dones_seen = 0;
    hold_valid = 1'b0;
    edge_n = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_to_done(input int budget);
    int n;
    n = 0;
    while (dones_seen == 0 && n < budget) begin
      tick();
      n++;
    end
    if (dones_seen == 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idx(input int idx, input int budget);
    int n;
    n = 0;
    while (!(strm.out_valid && strm.out_idx == 5'(idx)) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) chk("idx_timeout", 32'd0, 32'd1);
  endtask

  task automatic end_frame_checks(input string tag, input logic exp_match);
    tick();
    chk({tag, "_match_all"}, 32'(match_all), 32'(exp_match));
    chk({tag, "_beats"}, 32'(beats_seen), 32'(N));
    chk({tag, "_dones"}, 32'(dones_seen), 32'd1);
    chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_idle_valid"}, 32'(strm.out_valid), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_sel"}, 32'(sel), 32'd0);
    chk({tag, "_beat"}, 32'(cur_beat()), 32'd0);
    chk({tag, "_valid"}, 32'(strm.out_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_match_all"}, 32'(match_all), 32'd0);
  endtask

  initial begin
    int d0;
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    strm.out_ready = 1'b1;
    for (int i = 0; i < N; i++) mem[i] = 8'(i);
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    // Solved board, ready always high, exact cycle timing
    mode = 0;
    timing_on = 1'b1;
    start_frame();
    run_to_done(40);
    end_frame_checks("solved", 1'b1);

    // One wrong cell
    mem[7] = 8'hFF;
    start_frame();
    run_to_done(40);
    end_frame_checks("bad_cell", 1'b0);
    mem[7] = 8'd7;
    timing_on = 1'b0;

    // Back-pressure with ready pattern 1,0,0,1
    mode = 1;
    start_frame();
    run_to_done(200);
    end_frame_checks("stall", 1'b1);
    mode = 0;

    // Abort while beat 10 is presented
    start_frame();
    wait_idx(10, 40);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", 32'(strm.out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_match_all", 32'(match_all), 32'd0);
    d0 = dones_seen;
    sb.delete();
    repeat (5) tick();
    chk("abort_no_done", 32'(dones_seen), 32'(d0));
    chk("abort_no_beats", 32'(beats_seen), 32'd11);
    start_frame();
    run_to_done(40);
    end_frame_checks("after_abort", 1'b1);

    // Start together with abort stays idle
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", 32'(busy), 32'd0);
    tick();
    chk("start_abort_valid", 32'(strm.out_valid), 32'd0);

    // Repeated start pulses during the scan
    start_frame();
    for (int k = 0; k < 20; k++) begin
      start = (k % 5 == 2);
      tick();
    end
    start = 1'b0;
    run_to_done(40);
    end_frame_checks("restart", 1'b1);

    // Reset mid-frame at beat 12
    start_frame();
    wait_idx(12, 40);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_all_zero("mid_reset");
    sb.delete();
    beats_seen = 0;
    repeat (30) tick();
    chk("mid_reset_no_beats", 32'(beats_seen), 32'd0);
    chk("mid_reset_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
